if2de_ibuf: RTL and testbench

IF2DE_IBUF -- requirements
Module: if2de_ibuf

---
 rtl/if2de_ibuf_pkg.sv | 7 +
 rtl/if2de_ibuf_mem.sv | 24 ++
 rtl/if2de_ibuf.sv | 100 ++++++++++
 tb/tb_if2de_ibuf.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/if2de_ibuf_pkg.sv
// rtl/if2de_ibuf_pkg.sv - shared HiCore sizes used by the fetch-to-decode buffer
package if2de_ibuf_pkg;

   localparam int HiCore_IF2DE_SIZE = 32;
   localparam int HiCore_ADDR_SIZE  = 32;

endpackage

// File: rtl/if2de_ibuf_mem.sv
// rtl/if2de_ibuf_mem.sv - packet storage array, one write port, one async read port, no reset
module if2de_ibuf_mem #(
   parameter int DEPTH = 2,
   parameter int IW    = 32
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [IW-1:0]            wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [IW-1:0]            rdata_o
);

   logic [IW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if2de_ibuf.sv
// rtl/if2de_ibuf.sv - fetch-to-decode circular packet buffer with commit-redirect kill
// Optional combinational empty-bypass enabled by HICORE_IF2DE_BYPASS_EN.
module if2de_ibuf
   import if2de_ibuf_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int IW    = HiCore_IF2DE_SIZE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_if2de_valid,
   output logic                     i_if2de_ready,
   input  logic [IW-1:0]            i_if2de_info,
   input  logic                     i_if2de_cancel,
   output logic                     o_de_valid,
   input  logic                     o_de_ready,
   output logic [IW-1:0]            o_de_info,
   input  logic                     branch,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          kill;
   logic          buf_valid;
   logic          push;
   logic          pop;
   logic [IW-1:0] rd_data;

   assign kill          = flush | branch;
   assign i_if2de_ready = (count_q != CNT_FULL) && !kill;
   assign buf_valid     = (count_q != '0) && !kill;
   assign pop           = buf_valid && o_de_ready;
   assign o_count       = count_q;

`ifdef HICORE_IF2DE_BYPASS_EN
   logic byp;

   // An empty buffer hands the offered packet straight to decode; it is only stored if decode stalls.
   assign byp        = (count_q == '0) && i_if2de_valid && !i_if2de_cancel && !kill;
   assign o_de_valid = buf_valid || byp;
   assign o_de_info  = byp ? i_if2de_info : rd_data;
   assign push       = i_if2de_valid && i_if2de_ready && !i_if2de_cancel && !(byp && o_de_ready);
`else
   assign o_de_valid = buf_valid;
   assign o_de_info  = rd_data;
   assign push       = i_if2de_valid && i_if2de_ready && !i_if2de_cancel;
`endif

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (kill) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_ONE;
         if (pop)  rptr_d = rptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   if2de_ibuf_mem #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (i_if2de_info),
      .raddr_i (rptr_q),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_if2de_ibuf.sv
// tb/tb_if2de_ibuf.sv - scoreboard bench for if2de_ibuf: directed scenarios then random traffic
module tb_if2de_ibuf;

   localparam int DEPTH = 2;
   localparam int IW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

`ifdef HICORE_IF2DE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, in_cancel;
   logic [IW-1:0] in_info;
   logic          de_valid, de_ready;
   logic [IW-1:0] de_info;
   logic          br, fl;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;

   logic [IW-1:0] q[$];
   bit            m_ready;
   bit            m_byp;

   always #5 clk = ~clk;

   if2de_ibuf #(.DEPTH(DEPTH), .IW(IW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_if2de_valid  (in_valid),
      .i_if2de_ready  (in_ready),
      .i_if2de_info   (in_info),
      .i_if2de_cancel (in_cancel),
      .o_de_valid     (de_valid),
      .o_de_ready     (de_ready),
      .o_de_info      (de_info),
      .branch         (br),
      .flush          (fl),
      .o_count        (count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: expected outputs come from the packet queue, not from the DUT.
   always @(negedge clk) begin
      bit kill, exp_valid;
      kill      = fl || br;
      m_ready   = (q.size() != DEPTH) && !kill;
      exp_valid = !kill && (q.size() != 0 || (BYP && in_valid && !in_cancel));
      m_byp     = 1'b0;
      chk("count", 64'(count), 64'(q.size()));
      chk("ready", 64'(in_ready), 64'(m_ready));
      chk("valid", 64'(de_valid), 64'(exp_valid));
      if (exp_valid && de_valid) begin
         if (q.size() != 0) chk("info", 64'(de_info), 64'(q[0]));
         else               chk("bypass_info", 64'(de_info), 64'(in_info));
         if (de_ready) begin
            if (q.size() != 0) void'(q.pop_front());
            else               m_byp = 1'b1;
         end
      end
   end

   task automatic step(input logic rst, input logic v, input logic [IW-1:0] d, input logic c,
                       input logic f, input logic b, input logic r);
      @(posedge clk);
      #1;
      rst_n = rst; in_valid = v; in_info = d; in_cancel = c; fl = f; br = b; de_ready = r;
      if (!rst) q.delete();
      #6;
      if (rst) begin
         if (f || b) q.delete();
         else if (v && m_ready && !c && !m_byp) q.push_back(d);
      end
   endtask

   task automatic idle(input logic r);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, r);
   endtask

   task automatic offer(input logic [IW-1:0] d, input logic r);
      step(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, r);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_info = '0; in_cancel = 1'b0;
      fl = 1'b0; br = 1'b0; de_ready = 1'b0;
      repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);

      // Fill to full, offer while full, then drain in order.
      offer(32'hA0, 1'b0);
      offer(32'hA1, 1'b0);
      offer(32'hAF, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Simultaneous push and pop at count 1.
      offer(32'hB1, 1'b0);
      offer(32'hB2, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush, branch and both together while full, then push again.
      offer(32'hE0, 1'b0);
      offer(32'hE1, 1'b0);
      step(1'b1, 1'b1, 32'hEE, 1'b0, 1'b1, 1'b0, 1'b1);
      offer(32'hE5, 1'b0);
      step(1'b1, 1'b1, 32'hEF, 1'b0, 1'b0, 1'b1, 1'b1);
      offer(32'hE6, 1'b0);
      offer(32'hE7, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(1'b1);

      // Cancelled offer is consumed but never stored.
      step(1'b1, 1'b1, 32'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Pointer wrap: five overlapped push/pop pairs.
      offer(32'h50, 1'b0);
      for (int i = 1; i <= 5; i++) offer(32'h50 + IW'(i), 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Reset asserted with packets in flight.
      offer(32'h70, 1'b0);
      offer(32'h71, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Bypass case: empty buffer, decode ready.
      offer(32'hD4, 1'b1);
      idle(1'b1);

      for (int n = 0; n < 3000; n++) begin
         logic rr, vv, cc, ff, bb, dr;
         rr = ($urandom_range(0, 199) != 0);
         vv = rr && ($urandom_range(0, 9) < 6);
         cc = ($urandom_range(0, 9) == 0);
         ff = ($urandom_range(0, 29) == 0);
         bb = ($urandom_range(0, 29) == 0);
         dr = ($urandom_range(0, 1) == 1);
         step(rr, vv, $urandom, cc, ff, bb, dr);
      end
      idle(1'b1);
      idle(1'b1);
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
